// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Purpose  : Shares one serial transmitter between the ring forward path and
//            the local (router core) path. The winning packet is captured into
//            a holding register and presented on the TX_Data/TX_Data_Valid
//            handshake. After each accepted frame an inter-frame gap is
//            enforced. A frame the transmitter will not take within TIMEOUT
//            cycles is dropped.
// Ports    : Clk_R, Rst_n         - clock, asynchronous active-low reset
//            Fwd_Valid/Data/Ready - forward source (Ready = 1-cycle capture pulse)
//            Loc_Valid/Data/Ready - local source, eligible only with Has_Token
//            Has_Token            - router holds the token
//            TX_Ready             - transmitter can accept a frame
//            TX_Data_Valid/Data   - holding register toward the transmitter
//            Grant_Id             - 00 none, 01 forward, 10 local
//            Tx_Done/Tx_Timeout   - 1-cycle pulses: frame accepted / dropped
// Revision : 1.0 - initial release
// ============================================================================
module tx_arbiter #(
    parameter int DATA_W     = 55,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic              Clk_R,
    input  logic              Rst_n,
    input  logic              Fwd_Valid,
    input  logic [DATA_W-1:0] Fwd_Data,
    output logic              Fwd_Ready,
    input  logic              Loc_Valid,
    input  logic [DATA_W-1:0] Loc_Data,
    output logic              Loc_Ready,
    input  logic              Has_Token,
    input  logic              TX_Ready,
    output logic              TX_Data_Valid,
    output logic [DATA_W-1:0] TX_Data,
    output logic [1:0]        Grant_Id,
    output logic              Tx_Done,
    output logic              Tx_Timeout
);

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_FWD  = 2'b01;
    localparam logic [1:0] GRANT_LOC  = 2'b10;

    // Gap counter only has to hold GAP_CYCLES-1.
    localparam int             GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [7:0]     TOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic             last_loc;   // 1: most recent grant went to the local path
    logic [7:0]       tout_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic fwd_el;
    logic loc_el;
    logic pick_loc;

    assign fwd_el = Fwd_Valid;
    assign loc_el = Loc_Valid & Has_Token;
    // Local wins when it is the only candidate, or on a tie when forward
    // had the previous grant.
    assign pick_loc = loc_el & (~fwd_el | ~last_loc);

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= S_IDLE;
            last_loc      <= 1'b1;
            tout_cnt      <= '0;
            gap_cnt       <= '0;
            Fwd_Ready     <= 1'b0;
            Loc_Ready     <= 1'b0;
            TX_Data_Valid <= 1'b0;
            TX_Data       <= '0;
            Grant_Id      <= GRANT_NONE;
            Tx_Done       <= 1'b0;
            Tx_Timeout    <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            Fwd_Ready  <= 1'b0;
            Loc_Ready  <= 1'b0;
            Tx_Done    <= 1'b0;
            Tx_Timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (fwd_el || loc_el) begin
                        TX_Data       <= pick_loc ? Loc_Data : Fwd_Data;
                        Grant_Id      <= pick_loc ? GRANT_LOC : GRANT_FWD;
                        last_loc      <= pick_loc;
                        Fwd_Ready     <= ~pick_loc;
                        Loc_Ready     <= pick_loc;
                        TX_Data_Valid <= 1'b1;
                        tout_cnt      <= '0;
                        state         <= S_SEND;
                    end
                end

                S_SEND: begin
                    // Token loss is deliberately ignored here: a captured
                    // local frame is always allowed to complete.
                    if (TX_Ready) begin
                        Tx_Done       <= 1'b1;
                        TX_Data_Valid <= 1'b0;
                        Grant_Id      <= GRANT_NONE;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end else if (tout_cnt == TOUT_LAST) begin
                        // This edge is the TIMEOUT-th cycle without acceptance.
                        Tx_Timeout    <= 1'b1;
                        TX_Data_Valid <= 1'b0;
                        Grant_Id      <= GRANT_NONE;
                        state         <= S_IDLE;
                    end else begin
                        tout_cnt <= tout_cnt + 8'd1;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Purpose  : Self-checking bench for tx_arbiter. Source drivers feed packet
//            queues, a sink drives TX_Ready from per-frame plans, and a
//            monitor pops expected frames from a scoreboard queue whenever
//            the DUT presents a new frame.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter;

    localparam int DATA_W     = 55;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 255;
    localparam int DRAIN_MAX  = 20000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              Fwd_Valid = 1'b0;
    logic [DATA_W-1:0] Fwd_Data = '0;
    logic              Fwd_Ready;
    logic              Loc_Valid = 1'b0;
    logic [DATA_W-1:0] Loc_Data = '0;
    logic              Loc_Ready;
    logic              Has_Token = 1'b0;
    logic              TX_Ready = 1'b0;
    logic              TX_Data_Valid;
    logic [DATA_W-1:0] TX_Data;
    logic [1:0]        Grant_Id;
    logic              Tx_Done;
    logic              Tx_Timeout;

    always #5 clk = ~clk;

    tx_arbiter #(
        .DATA_W    (DATA_W),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .Clk_R        (clk),
        .Rst_n        (rst_n),
        .Fwd_Valid    (Fwd_Valid),
        .Fwd_Data     (Fwd_Data),
        .Fwd_Ready    (Fwd_Ready),
        .Loc_Valid    (Loc_Valid),
        .Loc_Data     (Loc_Data),
        .Loc_Ready    (Loc_Ready),
        .Has_Token    (Has_Token),
        .TX_Ready     (TX_Ready),
        .TX_Data_Valid(TX_Data_Valid),
        .TX_Data      (TX_Data),
        .Grant_Id     (Grant_Id),
        .Tx_Done      (Tx_Done),
        .Tx_Timeout   (Tx_Timeout)
    );

    typedef struct {
        logic [1:0]        gid;
        logic [DATA_W-1:0] data;
        bit                to;   // transmitter never accepts: expect timeout
        int                w;    // cycles of TX_Ready low before acceptance
    } frame_t;

    frame_t            exp_q[$];
    frame_t            plan_q[$];
    logic [DATA_W-1:0] fwd_q[$];
    logic [DATA_W-1:0] loc_q[$];
    int                tests = 0;
    int                fails = 0;
    bit                model_last_loc = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[DATA_W-1:0];
    endfunction

    task automatic push_exp(input logic [1:0] gid, input logic [DATA_W-1:0] d,
                            input bit to, input int w);
        frame_t f;
        f.gid = gid; f.data = d; f.to = to; f.w = w;
        exp_q.push_back(f);
        plan_q.push_back(f);
    endtask

    // ---------------- source drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (Fwd_Ready && fwd_q.size() > 0) void'(fwd_q.pop_front());
                if (Loc_Ready && loc_q.size() > 0) void'(loc_q.pop_front());
            end
            Fwd_Valid = (fwd_q.size() > 0);
            Fwd_Data  = (fwd_q.size() > 0) ? fwd_q[0] : '0;
            Loc_Valid = (loc_q.size() > 0);
            Loc_Data  = (loc_q.size() > 0) ? loc_q[0] : '0;
        end
    end

    // ---------------- transmitter sink ----------------
    initial begin
        frame_t p;
        bit     active;
        bit     pv;
        int     cnt;
        active = 1'b0; pv = 1'b0; cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                active = 1'b0; pv = 1'b0; TX_Ready = 1'b0;
            end else begin
                if (TX_Data_Valid && !pv) begin
                    active = (plan_q.size() > 0);
                    if (active) p = plan_q.pop_front();
                    cnt = 0;
                end
                pv = TX_Data_Valid;
                if (TX_Data_Valid && active) TX_Ready = !p.to && (cnt >= p.w);
                else if (TX_Data_Valid)      TX_Ready = 1'b1;
                else                         TX_Ready = 1'($urandom_range(0, 1));
                cnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        frame_t cur;
        bit act, pv, pfr, plr, gapchk, last_to, stable;
        int vc, low;
        act = 0; pv = 0; pfr = 0; plr = 0; gapchk = 0; last_to = 0; stable = 1; vc = 0; low = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 0; gapchk = 0; vc = 0; low = 0;
            end else begin
                if (Fwd_Ready || Loc_Ready)
                    check("ready_exclusive", {63'b0, (Fwd_Ready & Loc_Ready)}, 64'd0);
                if (Fwd_Ready) check("fwd_ready_pulse_width", {63'b0, pfr}, 64'd0);
                if (Loc_Ready) check("loc_ready_pulse_width", {63'b0, plr}, 64'd0);

                if (Tx_Done || Tx_Timeout) begin
                    check("done_timeout_exclusive", {63'b0, (Tx_Done & Tx_Timeout)}, 64'd0);
                    if (!act) begin
                        check("end_without_frame", 64'd1, 64'd0 + {63'b0, act});
                    end else begin
                        check("end_is_timeout", {63'b0, Tx_Timeout}, {63'b0, cur.to});
                        check("valid_cycles", 64'(vc), cur.to ? 64'(TIMEOUT) : 64'(cur.w + 1));
                        check("frame_held_stable", {63'b0, stable}, 64'd1);
                        check("valid_dropped_at_end", {63'b0, TX_Data_Valid}, 64'd0);
                        if (Tx_Done) check("grant_cleared_on_done", {62'b0, Grant_Id}, 64'd0);
                    end
                    act = 0; last_to = Tx_Timeout; low = 0;
                    gapchk = (exp_q.size() > 0);
                end

                if (TX_Data_Valid && !pv) begin
                    if (gapchk)
                        check("gap_cycles", 64'(low), last_to ? 64'd1 : 64'(GAP_CYCLES + 1));
                    gapchk = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {63'b0, TX_Data_Valid}, 64'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        act = 1; vc = 1; stable = 1;
                        check("grant_id", {62'b0, Grant_Id}, {62'b0, cur.gid});
                        check("tx_data", {9'b0, TX_Data}, {9'b0, cur.data});
                        check("ready_matches_grant", {62'b0, Loc_Ready, Fwd_Ready}, {62'b0, cur.gid});
                    end
                end else if (TX_Data_Valid) begin
                    vc++;
                    if (TX_Data !== cur.data || Grant_Id !== cur.gid) stable = 0;
                end else begin
                    low++;
                end
            end
            pv  = TX_Data_Valid;
            pfr = Fwd_Ready;
            plr = Loc_Ready;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || plan_q.size() > 0 || TX_Data_Valid ||
                fwd_q.size() > 0 || (Has_Token && loc_q.size() > 0)) && n < DRAIN_MAX) begin
            @(negedge clk);
            n++;
        end
        repeat (GAP_CYCLES + 3) @(negedge clk);
        check(name, {63'b0, (n < DRAIN_MAX)}, 64'd1);
    endtask

    // Round-robin reference: each grant decision sees which queues are non-empty.
    task automatic run_burst(input int nf, input int nl, input bit tok);
        logic [DATA_W-1:0] fd[$];
        logic [DATA_W-1:0] ld[$];
        int  f, l;
        bit  fe, le, pl;
        f = 0; l = 0;
        @(negedge clk);
        for (int i = 0; i < nf; i++) fd.push_back(rnd_data());
        for (int i = 0; i < nl; i++) ld.push_back(rnd_data());
        while (f < nf || (tok && l < nl)) begin
            fe = (f < nf);
            le = tok && (l < nl);
            if (fe && le) pl = !model_last_loc;
            else          pl = le;
            if (pl) begin
                push_exp(2'b10, ld[l], ($urandom_range(0, 9) == 0), int'($urandom_range(0, 5)));
                l++;
            end else begin
                push_exp(2'b01, fd[f], ($urandom_range(0, 9) == 0), int'($urandom_range(0, 5)));
                f++;
            end
            model_last_loc = pl;
        end
        Has_Token = tok;
        foreach (fd[i]) fwd_q.push_back(fd[i]);
        foreach (ld[i]) loc_q.push_back(ld[i]);
        wait_idle("burst_drain");
        if (!tok) loc_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int bad;
        logic [DATA_W-1:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {57'b0, Fwd_Ready, Loc_Ready, TX_Data_Valid, Grant_Id, Tx_Done, Tx_Timeout}, 64'd0);
        check("reset_tx_data", {9'b0, TX_Data}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {57'b0, Fwd_Ready, Loc_Ready, TX_Data_Valid, Grant_Id, Tx_Done, Tx_Timeout}, 64'd0);

        // All-ones forward packet, immediate acceptance, then a second frame
        // to measure the gap.
        d = '1;
        push_exp(2'b01, d, 1'b0, 0);
        d = rnd_data();
        push_exp(2'b01, d, 1'b0, 0);
        fwd_q.push_back(55'h7F_FFFF_FFFF_FFFF);
        fwd_q.push_back(d);
        model_last_loc = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!Fwd_Ready && k < 20);
        check("fwd_capture_latency", 64'(k), 64'd2);
        wait_idle("first_frames_drain");

        // Local without token is ignored, then granted the cycle after token.
        Has_Token = 1'b0;
        d = rnd_data();
        push_exp(2'b10, d, 1'b0, 2);
        loc_q.push_back(d);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (Loc_Ready || TX_Data_Valid) bad++;
        end
        check("no_grant_without_token", 64'(bad), 64'd0);
        Has_Token = 1'b1;
        @(negedge clk);
        check("loc_ready_after_token", {63'b0, Loc_Ready}, 64'd1);
        model_last_loc = 1'b1;
        wait_idle("token_frame_drain");

        // Alternation with both sources saturated.
        run_burst(4, 4, 1'b1);

        // Timeout on a forward frame with a second forward frame pending.
        @(negedge clk);
        d = rnd_data();
        push_exp(2'b01, d, 1'b1, 0);
        fwd_q.push_back(d);
        d = rnd_data();
        push_exp(2'b01, d, 1'b0, 1);
        fwd_q.push_back(d);
        model_last_loc = 1'b0;
        wait_idle("timeout_drain");

        // Token drops while a local frame is in SEND.
        Has_Token = 1'b1;
        d = rnd_data();
        push_exp(2'b10, d, 1'b0, 10);
        loc_q.push_back(d);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!Loc_Ready && k < 20);
        check("loc_granted_before_drop", {63'b0, Loc_Ready}, 64'd1);
        Has_Token = 1'b0;
        model_last_loc = 1'b1;
        wait_idle("token_drop_drain");

        // Randomised bursts.
        for (int i = 0; i < 8; i++)
            run_burst(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                      ($urandom_range(0, 3) != 0));

        // Asynchronous reset in the middle of SEND.
        @(negedge clk);
        d = rnd_data();
        push_exp(2'b01, d, 1'b1, 0);
        fwd_q.push_back(d);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!TX_Data_Valid && k < 20);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {63'b0, TX_Data_Valid}, 64'd0);
        check("async_reset_grant", {62'b0, Grant_Id}, 64'd0);
        check("async_reset_data", {9'b0, TX_Data}, 64'd0);
        fwd_q.delete();
        loc_q.delete();
        exp_q.delete();
        plan_q.delete();
        model_last_loc = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_burst(1, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
